uart_tx_param: RTL and testbench

Parametrised UART transmitter, the successor to the fixed 8N1 TX block in the APB UART peripheral.
- Configurable data width, parity mode and stop-bit count.
- Paced by the shared external baud_tick, rising-edge detected internally.
- Accepts words over a valid/ready handshake into a holding register, so back-to-back frames go out with no idle gap.
- Sits between the APB register slice and the serial pin.

---
 rtl/uart_tx_param.sv | 230 +++++++++++++++++++++++
 tb/tb_uart_tx_param.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: configurable data width, parity and stop bits, paced by baud_tick.
// Define UART_TX_FIFO_EN to replace the single holding register with a FIFO_DEPTH-entry TX FIFO.
module uart_tx_param #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic                 baud_tick,
    output logic                 d_out,
    output logic                 t_busy,
    output logic                 uart_ack,
    output logic                 tx_done
`ifdef UART_TX_FIFO_EN
    ,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
`endif
);

    localparam int IW = $clog2(DATA_BITS);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    if (DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
        FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
        $error("uart_tx_param: illegal parameter value");
    end

    state_t               state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 par_q, par_d;
    logic                 d_out_q, d_out_d;
    logic                 busy_q, busy_d;
    logic                 ack_q, ack_d;
    logic                 done_q, done_d;
    logic                 baud_q;
    logic                 tick;
    logic                 push;
    logic                 load;
    logic                 have_word;
    logic [DATA_BITS-1:0] head;

    assign tick = baud_tick & ~baud_q;
    assign push = tx_valid & tx_ready;

`ifdef UART_TX_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [AW:0]          count_q, count_d;

    assign tx_ready   = (count_q != (AW+1)'(FIFO_DEPTH));
    assign have_word  = (count_q != '0);
    assign head       = mem_q[rd_ptr_q];
    assign fifo_count = count_q;

    // A simultaneous push and pop cancel in the count; pointers wrap naturally (power-of-2 depth).
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(load);
        count_d  = count_q + (AW+1)'(push) - (AW+1)'(load);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= tx_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
`else
    logic [DATA_BITS-1:0] hold_q, hold_d;
    logic                 hold_full_q, hold_full_d;

    assign tx_ready  = ~hold_full_q;
    assign have_word = hold_full_q;
    assign head      = hold_q;

    // Push needs an empty register and load needs a full one, so they never collide.
    always_comb begin
        hold_d      = push ? tx_data : hold_q;
        hold_full_d = push | (hold_full_q & ~load);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else begin
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        idx_d      = idx_q;
        stop_cnt_d = stop_cnt_q;
        par_d      = par_q;
        d_out_d    = d_out_q;
        busy_d     = busy_q;
        ack_d      = push;
        done_d     = 1'b0;
        load       = 1'b0;

        case (state_q)
            IDLE: begin
                d_out_d = 1'b1;
                if (tick && have_word) begin
                    load = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    d_out_d = shift_q[0];
                    idx_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    if (idx_q == IW'(DATA_BITS - 1)) begin
                        stop_cnt_d = 1'b0;
                        if (PARITY_EN != 0) begin
                            d_out_d = par_q;
                            state_d = PARITY;
                        end else begin
                            d_out_d = 1'b1;
                            state_d = STOP;
                        end
                    end else begin
                        idx_d   = idx_q + IW'(1);
                        shift_d = shift_q >> 1;
                        d_out_d = shift_q[1];
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    d_out_d    = 1'b1;
                    stop_cnt_d = 1'b0;
                    state_d    = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
                        done_d = 1'b1;
                        if (have_word) begin
                            load = 1'b1;
                        end else begin
                            busy_d  = 1'b0;
                            state_d = IDLE;
                        end
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                d_out_d = 1'b1;
                busy_d  = 1'b0;
            end
        endcase

        // Loading the next word drives its start bit straight away, so frames chain with no idle gap.
        if (load) begin
            shift_d = head;
            par_d   = (^head) ^ (PARITY_ODD != 0);
            d_out_d = 1'b0;
            busy_d  = 1'b1;
            state_d = START;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            idx_q      <= '0;
            stop_cnt_q <= 1'b0;
            par_q      <= 1'b0;
            d_out_q    <= 1'b1;
            busy_q     <= 1'b0;
            ack_q      <= 1'b0;
            done_q     <= 1'b0;
            baud_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            idx_q      <= idx_d;
            stop_cnt_q <= stop_cnt_d;
            par_q      <= par_d;
            d_out_q    <= d_out_d;
            busy_q     <= busy_d;
            ack_q      <= ack_d;
            done_q     <= done_d;
            baud_q     <= baud_tick;
        end
    end

    assign d_out    = d_out_q;
    assign t_busy   = busy_q;
    assign uart_ack = ack_q;
    assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: three configurations (8N1, 7-bit odd parity 2 stop, 9-bit even parity 1 stop)
// with a line decoder feeding a per-instance scoreboard of expected frames.
module tb_uart_tx_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       baud_tick;
    logic [7:0] td0;
    logic [6:0] td1;
    logic [8:0] td2;
    logic [2:0] tv, rdy, line, busy, ack, done;
`ifdef UART_TX_FIFO_EN
    logic [2:0] fc0, fc1, fc2;
    localparam int CAP = 4;
`else
    localparam int CAP = 1;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        int         which;
        logic [8:0] data;
        logic [15:0] frame;
    } vec_t;

    vec_t        vecs[11];
    logic [15:0] q0[$], q1[$], q2[$];
    int          exp_ack[3], exp_done[3], nack[3], ndone[3];
    int          nbits[3], gap[3], last_gap[3];
    logic [15:0] bits[3];
    logic [2:0]  in_frame;
    logic        bt_prev, tk;
    int          bcnt;

    always #5 clk = ~clk;

    uart_tx_param #(.DATA_BITS(8)) dut0 (
        .clk(clk), .rst(rst), .tx_data(td0), .tx_valid(tv[0]), .tx_ready(rdy[0]),
        .baud_tick(baud_tick), .d_out(line[0]), .t_busy(busy[0]), .uart_ack(ack[0]), .tx_done(done[0])
`ifdef UART_TX_FIFO_EN
        , .fifo_count(fc0)
`endif
    );

    uart_tx_param #(.DATA_BITS(7), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) dut1 (
        .clk(clk), .rst(rst), .tx_data(td1), .tx_valid(tv[1]), .tx_ready(rdy[1]),
        .baud_tick(baud_tick), .d_out(line[1]), .t_busy(busy[1]), .uart_ack(ack[1]), .tx_done(done[1])
`ifdef UART_TX_FIFO_EN
        , .fifo_count(fc1)
`endif
    );

    uart_tx_param #(.DATA_BITS(9), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut2 (
        .clk(clk), .rst(rst), .tx_data(td2), .tx_valid(tv[2]), .tx_ready(rdy[2]),
        .baud_tick(baud_tick), .d_out(line[2]), .t_busy(busy[2]), .uart_ack(ack[2]), .tx_done(done[2])
`ifdef UART_TX_FIFO_EN
        , .fifo_count(fc2)
`endif
    );

    // Baud strobe held high for two clocks so only its rising edge may count as a tick.
    always @(negedge clk) begin
        bcnt      = (bcnt == 5) ? 0 : bcnt + 1;
        baud_tick = (bcnt < 2);
    end

    function automatic int db_of(input int w);
        return (w == 0) ? 8 : (w == 1) ? 7 : 9;
    endfunction

    function automatic int pe_of(input int w);
        return (w == 0) ? 0 : 1;
    endfunction

    function automatic int sb_of(input int w);
        return (w == 1) ? 2 : 1;
    endfunction

    function automatic int flen(input int w);
        return 1 + db_of(w) + pe_of(w) + sb_of(w);
    endfunction

    // Line samples in order: bit 0 is the start bit, then data LSB first, parity, stop bits.
    function automatic logic [15:0] model_frame(input int w, input logic [8:0] d);
        logic [15:0] f;
        logic        p;
        f = '0;
        p = 1'b0;
        for (int k = 0; k < db_of(w); k++) begin
            f[1+k] = d[k];
            p      = p ^ d[k];
        end
        if (pe_of(w) != 0) f[1+db_of(w)] = (w == 1) ? ~p : p;
        for (int k = 0; k < sb_of(w); k++) f[1+db_of(w)+pe_of(w)+k] = 1'b1;
        return f;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string msg);
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL %s", msg);
    endtask

    task automatic finish_frame(input int i);
        logic [15:0] e;
        bit          ok;
        ok = 1'b0;
        case (i)
            0:       if (q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
            1:       if (q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); ok = 1'b1; end
        endcase
        if (!ok) fail($sformatf("unexpected frame dut%0d: got 0x%0h, expected none", i, bits[i]));
        else     checkOutput($sformatf("frame dut%0d", i), {16'h0, bits[i]}, {16'h0, e});
    endtask

    // Line decoder: samples each line just after every tick edge.
    always @(posedge clk) begin
        if (rst) begin
            tk      = baud_tick & ~bt_prev;
            bt_prev = baud_tick;
        end else begin
            tk      = 1'b0;
            bt_prev = 1'b0;
        end
        #1;
        if (!rst) begin
            in_frame = '0;
            for (int i = 0; i < 3; i++) gap[i] = 0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (ack[i])  nack[i]++;
                if (done[i]) ndone[i]++;
                if (tk) begin
                    if (!in_frame[i]) begin
                        if (!line[i]) begin
                            in_frame[i] = 1'b1;
                            bits[i]     = '0;
                            nbits[i]    = 1;
                            last_gap[i] = gap[i];
                        end else begin
                            gap[i]++;
                        end
                    end else begin
                        bits[i][nbits[i]] = line[i];
                        nbits[i]++;
                        if (nbits[i] == flen(i)) begin
                            in_frame[i] = 1'b0;
                            gap[i]      = 0;
                            finish_frame(i);
                        end
                    end
                end
            end
        end
    end

    task automatic applyStimulus(input int w, input logic [8:0] d, input logic [15:0] fr);
        int n;
        n = 0;
        @(negedge clk);
        case (w)
            0:       td0 = d[7:0];
            1:       td1 = d[6:0];
            default: td2 = d;
        endcase
        tv[w] = 1'b1;
        while (!rdy[w] && n < 2000) begin
            @(negedge clk);
            n++;
            checkOutput($sformatf("no ack while not ready dut%0d", w), {31'h0, ack[w]}, 32'h0);
        end
        if (n >= 2000) begin
            fail($sformatf("send timeout dut%0d: waited %0d cycles, limit 2000", w, n));
            tv[w] = 1'b0;
        end else begin
            case (w)
                0:       q0.push_back(fr);
                1:       q1.push_back(fr);
                default: q2.push_back(fr);
            endcase
            exp_ack[w]++;
            exp_done[w]++;
            @(negedge clk);
            tv[w] = 1'b0;
            checkOutput($sformatf("uart_ack pulse dut%0d", w), {31'h0, ack[w]}, 32'h1);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((q0.size() + q1.size() + q2.size() != 0 || busy != 3'b000 || in_frame != 3'b000) &&
               n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) fail($sformatf("%s drain timeout: waited %0d cycles, limit 5000", tag, n));
        checkOutput({tag, " line idle"}, {29'h0, line}, 32'h7);
    endtask

    task automatic wait_busy0(input string tag);
        int n;
        n = 0;
        while (!busy[0] && n < 500) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, " t_busy rises"}, {31'h0, busy[0]}, 32'h1);
    endtask

    initial begin
        int n, drops, base_done, base_ack;

        vecs[0]  = '{which: 0, data: 9'h0A5, frame: 16'h034A};
        vecs[1]  = '{which: 1, data: 9'h055, frame: 16'h07AA};
        vecs[2]  = '{which: 2, data: 9'h007, frame: 16'h0C0E};
        vecs[3]  = '{which: 0, data: 9'h000, frame: 16'h0200};
        vecs[4]  = '{which: 1, data: 9'h007, frame: 16'h060E};
        vecs[5]  = '{which: 2, data: 9'h1FF, frame: 16'h0FFE};
        vecs[6]  = '{which: 0, data: 9'h0FF, frame: 16'h03FE};
        vecs[7]  = '{which: 1, data: 9'h000, frame: 16'h0700};
        vecs[8]  = '{which: 2, data: 9'h100, frame: 16'h0E00};
        vecs[9]  = '{which: 0, data: 9'h03C, frame: 16'h0278};
        vecs[10] = '{which: 2, data: 9'h0A5, frame: 16'h094A};

        rst = 1'b0;
        tv  = '0;
        td0 = '0;
        td1 = '0;
        td2 = '0;
        bcnt = 0;
        baud_tick = 1'b0;
        bt_prev = 1'b0;
        in_frame = '0;
        for (int i = 0; i < 3; i++) begin
            exp_ack[i] = 0; exp_done[i] = 0; nack[i] = 0; ndone[i] = 0;
            nbits[i] = 0; gap[i] = 0; last_gap[i] = 0; bits[i] = '0;
        end

        repeat (4) @(negedge clk);
        checkOutput("reset d_out", {29'h0, line}, 32'h7);
        checkOutput("reset t_busy", {29'h0, busy}, 32'h0);
        checkOutput("reset tx_ready", {29'h0, rdy}, 32'h7);
        checkOutput("reset uart_ack", {29'h0, ack}, 32'h0);
        checkOutput("reset tx_done", {29'h0, done}, 32'h0);
`ifdef UART_TX_FIFO_EN
        checkOutput("reset fifo_count", {23'h0, fc0, fc1, fc2}, 32'h0);
`endif
        rst = 1'b1;
        repeat (3) @(negedge clk);

        $display("[TB] table-driven frames");
        for (int v = 0; v < 11; v++) applyStimulus(vecs[v].which, vecs[v].data, vecs[v].frame);
        wait_idle("table");

        $display("[TB] back-to-back frames");
        base_done = ndone[0];
        base_ack  = nack[0];
        applyStimulus(0, 9'h011, model_frame(0, 9'h011));
        wait_busy0("b2b");
        n = 0;
        while (!(in_frame[0] && nbits[0] >= 3) && n < 500) begin
            @(negedge clk);
            n++;
        end
        applyStimulus(0, 9'h022, model_frame(0, 9'h022));
        drops = 0;
        n = 0;
        while (ndone[0] < base_done + 2 && n < 2000) begin
            @(negedge clk);
            n++;
            if (!busy[0] && ndone[0] < base_done + 2) drops++;
        end
        checkOutput("b2b t_busy drops", drops, 0);
        checkOutput("b2b idle ticks before 2nd start", last_gap[0], 0);
        checkOutput("b2b tx_done count", ndone[0] - base_done, 2);
        checkOutput("b2b uart_ack count", nack[0] - base_ack, 2);
        wait_idle("b2b");

        $display("[TB] reset mid-frame");
        applyStimulus(0, 9'h03C, model_frame(0, 9'h03C));
        n = 0;
        while (!(in_frame[0] && nbits[0] >= 4) && n < 500) begin
            @(negedge clk);
            n++;
        end
        rst = 1'b0;
        #1;
        checkOutput("abort d_out", {31'h0, line[0]}, 32'h1);
        checkOutput("abort t_busy", {31'h0, busy[0]}, 32'h0);
        checkOutput("abort tx_ready", {31'h0, rdy[0]}, 32'h1);
        q0.delete();
        exp_done[0]--;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        applyStimulus(0, 9'h03C, 16'h0278);
        wait_idle("after reset");

        $display("[TB] holding capacity");
        applyStimulus(0, 9'h0C1, model_frame(0, 9'h0C1));
        wait_busy0("capacity");
        for (int k = 0; k < CAP; k++) applyStimulus(0, 9'(9'h0D0 + k), model_frame(0, 9'(9'h0D0 + k)));
        checkOutput("full tx_ready", {31'h0, rdy[0]}, 32'h0);
`ifdef UART_TX_FIFO_EN
        checkOutput("full fifo_count", {29'h0, fc0}, CAP);
`endif
        applyStimulus(0, 9'h0E7, model_frame(0, 9'h0E7));
        wait_idle("capacity");
`ifdef UART_TX_FIFO_EN
        checkOutput("drained fifo_count", {29'h0, fc0}, 32'h0);
`endif

        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("tx_done total dut%0d", i), ndone[i], exp_done[i]);
            checkOutput($sformatf("uart_ack total dut%0d", i), nack[i], exp_ack[i]);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #3000000;
        fail("global timeout");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $fatal(1, "[TB] simulation did not finish");
    end

endmodule
